// File: rtl/axi_llc_sram_arb.sv
// Round-robin arbiter sharing one LLC SRAM port between NumReq requesters, with a
// latency-matched read response router and an idle-time ECC scrub trigger.
module axi_llc_sram_arb #(
   parameter int unsigned NumReq        = 4,
   parameter int unsigned NumWords      = 1024,
   parameter int unsigned DataWidth     = 128,
   parameter int unsigned ByteWidth     = 8,
   parameter int unsigned RespLatency   = 1,
   parameter int unsigned NumScrubLanes = 1,
   parameter int unsigned ScrubInterval = 256,
   localparam int unsigned AddrWidth    = (NumWords > 1) ? $clog2(NumWords) : 1,
   localparam int unsigned BeWidth      = (DataWidth + ByteWidth - 1) / ByteWidth,
   localparam int unsigned IdxWidth     = $clog2(NumReq)
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [NumReq-1:0]                   req_i,
   input  logic [NumReq-1:0]                   we_i,
   input  logic [NumReq-1:0][AddrWidth-1:0]    addr_i,
   input  logic [NumReq-1:0][DataWidth-1:0]    wdata_i,
   input  logic [NumReq-1:0][BeWidth-1:0]      be_i,
   output logic [NumReq-1:0]                   gnt_o,
   output logic [NumReq-1:0]                   rvalid_o,
   output logic [DataWidth-1:0]                rdata_o,
   output logic                                sram_req_o,
   output logic                                sram_we_o,
   output logic [AddrWidth-1:0]                sram_addr_o,
   output logic [DataWidth-1:0]                sram_wdata_o,
   output logic [BeWidth-1:0]                  sram_be_o,
   input  logic                                sram_gnt_i,
   input  logic [DataWidth-1:0]                sram_rdata_i,
   output logic [NumScrubLanes-1:0]            scrub_trigger_o
);

   logic [IdxWidth-1:0] rr_ptr, rr_ptr_next, winner, cand;
   logic                found;
   logic                handshake;

   logic [RespLatency-1:0]               pipe_valid;
   logic [RespLatency-1:0][IdxWidth-1:0] pipe_idx;

   // First asserted request at or after rr_ptr, wrapping.
   always_comb begin
      winner = rr_ptr;
      found  = 1'b0;
      cand   = '0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         cand = IdxWidth'((32'(rr_ptr) + i) % NumReq);
         if (!found && req_i[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   assign sram_req_o = |req_i;
   assign handshake  = sram_req_o & sram_gnt_i;

   always_comb begin
      sram_we_o    = 1'b0;
      sram_addr_o  = '0;
      sram_wdata_o = '0;
      sram_be_o    = '0;
      gnt_o        = '0;
      if (sram_req_o) begin
         sram_we_o    = we_i[winner];
         sram_addr_o  = addr_i[winner];
         sram_wdata_o = wdata_i[winner];
         sram_be_o    = be_i[winner];
         gnt_o[winner] = sram_gnt_i & rst_ni;
      end
   end

   always_comb begin
      rr_ptr_next = rr_ptr;
      if (handshake) begin
         rr_ptr_next = (winner == IdxWidth'(NumReq - 1)) ? '0 : winner + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr     <= '0;
         pipe_valid <= '0;
         pipe_idx   <= '0;
      end else begin
         rr_ptr        <= rr_ptr_next;
         pipe_valid[0] <= handshake & ~sram_we_o;
         pipe_idx[0]   <= winner;
         for (int unsigned i = 1; i < RespLatency; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_idx[i]   <= pipe_idx[i-1];
         end
      end
   end

   // Tail of the pipeline lines up with the macro's read data.
   always_comb begin
      rvalid_o = '0;
      rdata_o  = '0;
      if (pipe_valid[RespLatency-1]) begin
         rvalid_o[pipe_idx[RespLatency-1]] = 1'b1;
         rdata_o = sram_rdata_i;
      end
   end

   if (ScrubInterval == 0) begin : g_no_scrub
      assign scrub_trigger_o = '0;
   end else begin : g_scrub
      localparam int unsigned CntWidth = (ScrubInterval > 1) ? $clog2(ScrubInterval) : 1;
      localparam logic [CntWidth-1:0] CntMax = CntWidth'(ScrubInterval - 1);

      logic [CntWidth-1:0] scrub_cnt;
      logic                scrub_fire, scrub_pulse;

      // A saturated counter waits for an idle, ready macro before firing.
      assign scrub_fire = (scrub_cnt == CntMax) & ~sram_req_o & sram_gnt_i;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            scrub_cnt   <= '0;
            scrub_pulse <= 1'b0;
         end else begin
            scrub_pulse <= scrub_fire;
            if (scrub_fire) begin
               scrub_cnt <= '0;
            end else if (scrub_cnt != CntMax) begin
               scrub_cnt <= scrub_cnt + 1'b1;
            end
         end
      end

      assign scrub_trigger_o = {NumScrubLanes{scrub_pulse}};
   end

endmodule

// File: tb/tb_axi_llc_sram_arb.sv
// Directed bench for axi_llc_sram_arb: arbitration order, stalls, read routing,
// write/read data path, reset flushing and scrub timing against a small macro model.
module tb_axi_llc_sram_arb;

   localparam int unsigned NumReq = 4;
   localparam int unsigned AW     = 8;
   localparam int unsigned DW     = 32;
   localparam int unsigned BW     = 4;

   logic                       clk;
   logic                       rst_n;
   logic [NumReq-1:0]          req, we, gnt, rvalid;
   logic [NumReq-1:0][AW-1:0]  addr;
   logic [NumReq-1:0][DW-1:0]  wdata;
   logic [NumReq-1:0][BW-1:0]  be;
   logic [DW-1:0]              rdata;
   logic                       sram_req, sram_we, sram_gnt;
   logic [AW-1:0]              sram_addr;
   logic [DW-1:0]              sram_wdata, sram_rdata;
   logic [BW-1:0]              sram_be;
   logic [0:0]                 scrub;

   int total = 0;
   int bad   = 0;

   axi_llc_sram_arb #(
      .NumReq        (4),
      .NumWords      (256),
      .DataWidth     (32),
      .ByteWidth     (8),
      .RespLatency   (2),
      .NumScrubLanes (1),
      .ScrubInterval (8)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .req_i           (req),
      .we_i            (we),
      .addr_i          (addr),
      .wdata_i         (wdata),
      .be_i            (be),
      .gnt_o           (gnt),
      .rvalid_o        (rvalid),
      .rdata_o         (rdata),
      .sram_req_o      (sram_req),
      .sram_we_o       (sram_we),
      .sram_addr_o     (sram_addr),
      .sram_wdata_o    (sram_wdata),
      .sram_be_o       (sram_be),
      .sram_gnt_i      (sram_gnt),
      .sram_rdata_i    (sram_rdata),
      .scrub_trigger_o (scrub)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Macro model: word a initialised to 32'hA5A5_00aa, two-cycle read latency.
   logic [DW-1:0] mem [256];
   logic [DW-1:0] rd0, rd1;
   logic          mem_ready = 1'b0;

   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) mem[i] <= {16'hA5A5, 8'h00, 8'(i)};
         mem_ready <= 1'b1;
      end
      rd0 <= 32'hDEAD_BEEF;
      if (rst_n && sram_req && sram_gnt) begin
         if (sram_we) begin
            for (int b = 0; b < 4; b++) begin
               if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
         end else begin
            rd0 <= mem[sram_addr];
         end
      end
      rd1 <= rd0;
   end
   assign sram_rdata = rd1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0; be = '0; sram_gnt = 1'b1;
      for (int i = 0; i < 4; i++) be[i] = 4'hF;

      // Reset: combinational request follows, grant forced low
      req = 4'b1111;
      smp();
      chk("rst_gnt", gnt, 4'b0000);
      chk("rst_rvalid", rvalid, 4'b0000);
      chk("rst_scrub", scrub, 1'b0);
      chk("rst_sram_req", sram_req, 1'b1);
      req = '0;
      tick();
      rst_n = 1'b1;

      // Requesters 0 and 2 alternate
      addr[0] = 8'h03; addr[2] = 8'h05; req = 4'b0101;
      smp();
      chk("a0_gnt", gnt, 4'b0001);
      chk("a0_addr", sram_addr, 8'h03);
      chk("a0_rvalid", rvalid, 4'b0000);
      tick(); smp();
      chk("a1_gnt", gnt, 4'b0100);
      chk("a1_addr", sram_addr, 8'h05);
      tick(); smp();
      chk("a2_gnt", gnt, 4'b0001);
      chk("a2_rvalid", rvalid, 4'b0001);
      chk("a2_rdata", rdata, 32'hA5A5_0003);
      tick(); smp();
      chk("a3_gnt", gnt, 4'b0100);
      chk("a3_rvalid", rvalid, 4'b0100);
      chk("a3_rdata", rdata, 32'hA5A5_0005);
      tick();
      req = '0;
      smp();
      chk("a4_rvalid", rvalid, 4'b0001);
      chk("a4_rdata", rdata, 32'hA5A5_0003);
      chk("a4_sram_req", sram_req, 1'b0);
      chk("a4_sram_addr", sram_addr, 8'h00);
      tick(); smp();
      chk("a5_rvalid", rvalid, 4'b0100);
      chk("a5_rdata", rdata, 32'hA5A5_0005);
      tick(); smp();
      chk("a6_rvalid", rvalid, 4'b0000);
      chk("a6_rdata", rdata, 32'h0);
      tick();

      // Single read from 3 moves rr_ptr back to 0, then a stall with all requesting
      req = 4'b1000; addr[3] = 8'h07;
      smp();
      chk("b0_gnt", gnt, 4'b1000);
      tick();
      req = 4'b1111; we = 4'b1111; sram_gnt = 1'b0;
      for (int i = 0; i < 4; i++) begin
         addr[i]  = 8'(8'h20 + i);
         wdata[i] = 32'h1111_1111 * 32'(i + 1);
      end
      smp();
      chk("b1_gnt", gnt, 4'b0000);
      chk("b1_sram_req", sram_req, 1'b1);
      chk("b1_addr", sram_addr, 8'h20);
      tick(); smp();
      chk("b2_gnt", gnt, 4'b0000);
      chk("b2_rvalid", rvalid, 4'b1000);
      chk("b2_rdata", rdata, 32'hA5A5_0007);
      tick(); smp();
      chk("b3_gnt", gnt, 4'b0000);
      tick();
      sram_gnt = 1'b1;
      smp();
      chk("b4_gnt", gnt, 4'b0001);
      chk("b4_we", sram_we, 1'b1);
      chk("b4_wdata", sram_wdata, 32'h1111_1111);
      tick(); smp();
      chk("b5_gnt", gnt, 4'b0010);
      chk("b5_addr", sram_addr, 8'h21);
      tick(); smp();
      chk("b6_gnt", gnt, 4'b0100);
      tick(); smp();
      chk("b7_gnt", gnt, 4'b1000);
      chk("b7_rvalid", rvalid, 4'b0000);
      tick();

      // Requester 1: full write, read, partial write, read
      req = 4'b0010; we = 4'b0010; addr[1] = 8'h10; wdata[1] = 32'hCAFE_F00D; be[1] = 4'hF;
      smp();
      chk("c0_gnt", gnt, 4'b0010);
      chk("c0_we", sram_we, 1'b1);
      chk("c0_wdata", sram_wdata, 32'hCAFE_F00D);
      chk("c0_be", sram_be, 4'hF);
      tick();
      we = 4'b0000;
      smp();
      chk("c1_gnt", gnt, 4'b0010);
      chk("c1_we", sram_we, 1'b0);
      chk("c1_rvalid", rvalid, 4'b0000);
      tick();
      we = 4'b0010; wdata[1] = 32'h0000_00AA; be[1] = 4'b0001;
      smp();
      chk("c2_rvalid", rvalid, 4'b0000);
      chk("c2_be", sram_be, 4'b0001);
      tick();
      we = 4'b0000; be[1] = 4'hF;
      smp();
      chk("c3_rvalid", rvalid, 4'b0010);
      chk("c3_rdata", rdata, 32'hCAFE_F00D);
      tick();
      req = '0;
      smp();
      chk("c4_rvalid", rvalid, 4'b0000);
      tick(); smp();
      chk("c5_rvalid", rvalid, 4'b0010);
      chk("c5_rdata", rdata, 32'hCAFE_F0AA);
      tick();

      // Requester 3 streams ten reads
      req = 4'b1000; we = '0;
      for (int k = 0; k < 10; k++) begin
         addr[3] = 8'(8'h40 + k);
         smp();
         chk("f_gnt", gnt, 4'b1000);
         if (k >= 2) begin
            chk("f_rvalid", rvalid, 4'b1000);
            chk("f_rdata", rdata, 32'hA5A5_0040 + 32'(k - 2));
         end
         tick();
      end
      req = '0;
      smp();
      chk("f10_rvalid", rvalid, 4'b1000);
      chk("f10_rdata", rdata, 32'hA5A5_0048);
      tick(); smp();
      chk("f11_rvalid", rvalid, 4'b1000);
      chk("f11_rdata", rdata, 32'hA5A5_0049);
      tick(); smp();
      chk("f12_rvalid", rvalid, 4'b0000);
      tick();

      // Reset right after a read grant drops the response
      req = 4'b0001; addr[0] = 8'h03;
      smp();
      chk("e0_gnt", gnt, 4'b0001);
      tick();
      req = '0; rst_n = 1'b0;
      smp();
      chk("e1_rvalid", rvalid, 4'b0000);
      tick();
      req = 4'b0001;
      smp();
      chk("e2_rvalid", rvalid, 4'b0000);
      chk("e2_gnt", gnt, 4'b0000);
      chk("e2_sram_req", sram_req, 1'b1);
      tick();
      rst_n = 1'b1; req = 4'b1111;
      smp();
      chk("e3_gnt", gnt, 4'b0001);
      chk("e3_rvalid", rvalid, 4'b0000);
      tick();
      req = '0;
      smp();
      chk("e4_rvalid", rvalid, 4'b0000);
      tick(); smp();
      chk("e5_rvalid", rvalid, 4'b0001);
      chk("e5_rdata", rdata, 32'hA5A5_0003);
      tick();

      // Scrub: pulses at 8 and 16, traffic 22..28 delays the next to 30, then 38
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; we = 4'b0001; addr[0] = 8'h30;
      for (int k = 0; k <= 38; k++) begin
         req = (k >= 22 && k <= 28) ? 4'b0001 : 4'b0000;
         smp();
         chk("d_scrub", scrub, (k == 8 || k == 16 || k == 30 || k == 38) ? 1'b1 : 1'b0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
